stream_link_fifo: RTL and testbench
===================================

Name: stream_link_fifo

Overview:
- Parametrised successor to the plain producer-to-consumer data/valid link.
- Inserts a DEPTH-entry first-word-fall-through buffer between a producer and a consumer, with valid/ready flow control on both sides.
- A LEGACY_MODE lets valid-only producers (no ready input) connect; words arriving while full are dropped and counted.
- Sits on any point-to-point data path in top-level integrations where producer and consumer rates differ.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- DEPTH, 4, number of buffer entries; power of two, 2..64.
- LEGACY_MODE, 0, 0 = producer honours in_ready; 1 = producer ignores in_ready, overflow words are dropped.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  producer data.
- in_valid  input  1  producer word present.
- in_ready  output  1  buffer can accept a word this cycle.
- out_data  output  DATA_WIDTH  head-of-buffer data.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts the head word.
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- drop_count  output  CNT_WIDTH  saturating count of dropped words.
- drop_pulse  output  1  one-cycle flag, high the cycle after a drop.

Behaviour:
- Reset: one clock, asynchronous, active-high. While rst is high, all outputs are 0: in_ready=0, out_valid=0, out_data=0, level=0, drop_count=0, drop_pulse=0. Storage flops and pointers are cleared to 0.
- in_ready is a registered signal. It rises on the first clk edge after rst deasserts. Thereafter in_ready = (level_next < DEPTH), registered.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- Storage: circular flop array with write and read pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0 with no special case.
- FWFT timing: a word pushed at edge N appears on out_data with out_valid=1 after edge N. Latency is 1 cycle; no combinational in-to-out path.
- out_data = storage[rd_ptr]. It is held stable while out_valid=1 and out_ready=0. It is don't-care when out_valid=0, except 0 after reset.
- level update: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- Full (level==DEPTH): in_ready=0. No same-cycle pass-through, even if a pop occurs that cycle; in_ready rises the cycle after the pop.
- Empty (level==0): out_valid=0. out_ready is ignored.
- Simultaneous push and pop at level 1: the head is popped and the new word becomes the head next cycle; out_valid stays 1.
- LEGACY_MODE=0: in_valid while in_ready=0 is a producer stall. It is not a drop; drop_count is unchanged.
- LEGACY_MODE=1: any cycle with in_valid=1 and in_ready=0 drops the word:
  - drop_count increments by 1 and saturates at 2^CNT_WIDTH-1 (no wrap);
  - drop_pulse=1 for exactly the following cycle;
  - back-to-back drops keep drop_pulse high continuously;
  - stored data is unaffected.
- in_ready=0 during the first post-reset cycle counts as a drop in LEGACY_MODE=1.
- Reset mid-operation: all contents are discarded immediately. The partially drained word is lost, and out_valid falls asynchronously.
- Registered outputs: in_ready, out_valid, level, drop_count and drop_pulse all come straight from flops.

Test Plan:
- Basic flow, DEPTH=4, DATA_WIDTH=8: push 0x11, 0x22, 0x33 with out_ready=1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its push; level never exceeds 1.
- Fill and stall: out_ready=0, push 0xA0..0xA5 with LEGACY_MODE=0 -> 4 accepted, level=4, in_ready=0, drop_count=0. Then out_ready=1 -> 0xA0..0xA3 out in order; producer resumes 0xA4 one cycle after the first pop.
- Wrap-around: 10 words 0x00..0x09 with alternating out_ready -> output order 0x00..0x09 exact; level stays within 0..4.
- Legacy overflow: LEGACY_MODE=1, CNT_WIDTH=4, out_ready=0, 24 consecutive valid words -> 4 stored, drop_count saturates at 15 and holds, drop_pulse high each cycle after a drop.
- Simultaneous push/pop at full: level=4, in_valid=1, out_ready=1 -> pop occurs, no push that cycle, level=3, in_ready=1 next cycle.
- Async reset mid-stream: assert rst between edges at level=3 -> out_valid, level and in_ready go 0 without a clock edge. After release, in_ready=1 after one edge, and the first new word emerges correctly.

Source files
------------

// File: rtl/stream_link_fifo.sv
// stream_link_fifo: DEPTH-entry first-word-fall-through buffer with valid/ready flow
// control on both sides, plus a legacy valid-only mode that drops and counts overflow words.
module stream_link_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int LEGACY_MODE = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic                       drop_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] STEP = PTR_W'(1);

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_next;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  cnt_sat;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // in_ready is low while full, so a legacy producer loses the word
  assign drop    = (LEGACY_MODE != 0) && in_valid && !in_ready;
  assign cnt_sat = &drop_count;

  assign out_data = storage[rd_ptr];

  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + ONE;
      2'b01:   level_next = level - ONE;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= in_data;
        wr_ptr          <= wr_ptr + STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + STEP;
      end
    end
  end

  // status flags are derived from the next occupancy so they stay flop outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      level     <= level_next;
      in_ready  <= (level_next < FULL);
      out_valid <= (level_next != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && !cnt_sat) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_link_fifo.sv
// Bench for stream_link_fifo: a flow-controlled and a legacy instance share one
// stimulus and are compared every cycle against queue-based reference models.
module tb_stream_link_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, out_valid0, drop_pulse0;
  logic [7:0] out_data0;
  logic [2:0] level0;
  logic [15:0] drop_count0;

  logic       in_ready1, out_valid1, drop_pulse1;
  logic [7:0] out_data1;
  logic [2:0] level1;
  logic [3:0] drop_count1;

  int n_chk = 0;
  int n_fail = 0;
  bit done = 0;

  always #5 clk = ~clk;

  stream_link_fifo #(
    .DATA_WIDTH(8), .DEPTH(4), .LEGACY_MODE(0), .CNT_WIDTH(16)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .level(level0), .drop_count(drop_count0), .drop_pulse(drop_pulse0)
  );

  stream_link_fifo #(
    .DATA_WIDTH(8), .DEPTH(4), .LEGACY_MODE(1), .CNT_WIDTH(4)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .level(level1), .drop_count(drop_count1), .drop_pulse(drop_pulse1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain queues, ready = room left after this edge
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit rdy0 = 0, rdy1 = 0, pulse1 = 0;
  int cnt1 = 0;
  bit p0, o0, p1, o1, d1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      rdy0 = 0;
      rdy1 = 0;
      cnt1 = 0;
      pulse1 = 0;
    end else begin
      p0 = in_valid && rdy0;
      o0 = (q0.size() > 0) && out_ready;
      if (o0) void'(q0.pop_front());
      if (p0) q0.push_back(in_data);
      rdy0 = q0.size() < 4;
      p1 = in_valid && rdy1;
      d1 = in_valid && !rdy1;
      o1 = (q1.size() > 0) && out_ready;
      if (o1) void'(q1.pop_front());
      if (p1) q1.push_back(in_data);
      rdy1 = q1.size() < 4;
      pulse1 = d1;
      if (d1 && cnt1 < 15) cnt1++;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("level0", level0, q0.size());
      chk("out_valid0", out_valid0, q0.size() != 0);
      chk("in_ready0", in_ready0, rdy0);
      chk("drop_count0", drop_count0, 0);
      chk("drop_pulse0", drop_pulse0, 0);
      if (q0.size() != 0) chk("out_data0", out_data0, q0[0]);
      chk("level1", level1, q1.size());
      chk("out_valid1", out_valid1, q1.size() != 0);
      chk("in_ready1", in_ready1, rdy1);
      chk("drop_count1", drop_count1, cnt1);
      chk("drop_pulse1", drop_pulse1, pulse1);
      if (q1.size() != 0) chk("out_data1", out_data1, q1[0]);
      if (rst) begin
        chk("rst_out_data0", out_data0, 0);
        chk("rst_out_data1", out_data1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int cyc;
    bit acc;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("reset_in_ready0", in_ready0, 0);
    chk("reset_level0", level0, 0);
    rst = 1'b0;

    // first post-reset cycle: stall for dut0, drop for dut1
    tick();
    chk("first_in_ready0", in_ready0, 1);
    chk("first_drop_count1", drop_count1, 1);
    chk("first_drop_pulse1", drop_pulse1, 1);
    chk("first_level0", level0, 0);
    tick();
    chk("w77_out", out_data0, 8'h77);
    chk("w77_level", level0, 1);

    // basic flow
    in_data = 8'h11;
    tick();
    chk("w11_out", out_data0, 8'h11);
    chk("w11_level", level0, 1);
    in_data = 8'h22;
    tick();
    chk("w22_out", out_data0, 8'h22);
    in_data = 8'h33;
    tick();
    chk("w33_out", out_data0, 8'h33);
    chk("w33_level", level0, 1);
    in_valid = 1'b0;
    repeat (2) tick();

    // fill and stall
    out_ready = 1'b0;
    in_valid = 1'b1;
    idx = 0;
    repeat (8) begin
      in_data = 8'hA0 + 8'(idx);
      acc = in_ready0;
      tick();
      if (acc) idx++;
    end
    chk("fill_level0", level0, 4);
    chk("fill_in_ready0", in_ready0, 0);
    chk("fill_drop_count0", drop_count0, 0);
    chk("fill_head", out_data0, 8'hA0);
    chk("fill_idx", idx, 4);
    out_ready = 1'b1;
    in_data = 8'hA4;
    tick();
    chk("unstall_head", out_data0, 8'hA1);
    chk("unstall_in_ready0", in_ready0, 1);
    chk("unstall_level0", level0, 3);
    tick();
    chk("resume_head", out_data0, 8'hA2);
    chk("resume_level0", level0, 3);
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();

    // wrap-around with alternating consumer
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 100) begin
      in_valid = 1'b1;
      in_data = 8'(idx);
      out_ready = cyc[0];
      acc = in_ready0;
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("wrap_done", idx, 10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    // legacy overflow and saturation
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_data = 8'hC0 + 8'(i);
      tick();
    end
    chk("ovf_drop_count1", drop_count1, 15);
    chk("ovf_level1", level1, 4);
    chk("ovf_pulse1", drop_pulse1, 1);
    chk("ovf_head1", out_data1, 8'hC0);
    chk("ovf_level0", level0, 4);
    chk("ovf_drop_count0", drop_count0, 0);

    // push and pop together while full
    out_ready = 1'b1;
    tick();
    chk("fullpop_level0", level0, 3);
    chk("fullpop_in_ready0", in_ready0, 1);
    chk("fullpop_level1", level1, 3);
    chk("fullpop_pulse1", drop_pulse1, 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("idle_level0", level0, 3);
    chk("idle_pulse1", drop_pulse1, 0);
    chk("idle_count1", drop_count1, 15);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid0", out_valid0, 0);
    chk("arst_level0", level0, 0);
    chk("arst_in_ready0", in_ready0, 0);
    chk("arst_out_data0", out_data0, 0);
    chk("arst_drop_count1", drop_count1, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    chk("rel_in_ready0", in_ready0, 1);
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    chk("rel_out_data0", out_data0, 8'h5A);
    chk("rel_out_valid0", out_valid0, 1);
    in_valid = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      tick();
    end

    @(posedge clk);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
